pbit_neuron: RTL and testbench

- Stochastic p-bit cell that consumes the signed scaled input current I_i produced by the p-bit MAC.
- Produces the p-bit state that feeds back into neighbouring MACs' p_in.
- On each update request, waits a programmable settle time for the combinational MAC to settle, then samples p = (I_in > rand) against a free-running LFSR. This is the digital form of m = sgn(tanh(I) + r).
- Keeps a saturating count of ones for sampling statistics.

---
 rtl/pbit_neuron.sv | 196 +++++++++++++++++++
 tb/tb_pbit_neuron.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pbit_neuron.sv
// -----------------------------------------------------------------------------
// pbit_neuron
//
// Stochastic p-bit cell. When an update is requested, the cell waits a
// programmable number of cycles so that the combinational MAC feeding I_in
// can settle. It then samples p = (I_in > rand), where rand is taken from a
// free-running 16-bit Fibonacci LFSR. This is the digital form of
// m = sgn(tanh(I) + r). A saturating counter records how many updates
// produced p = 1, which is used for sampling statistics.
//
// Parameters
//   weight_precision : width of the signed I_in and of the random comparand (2..16)
//   SETTLE_CYCLES    : cycles spent in SETTLE after an accepted request (0..255)
//   SEED             : LFSR reset value (0 selects 16'hACE1)
//   P_INIT           : p_out value after reset
//   COUNT_WIDTH      : width of ones_count
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   upd_req    in   request one update (only looked at while idle)
//   I_in       in   signed input current from the MAC, two's complement
//   clr_count  in   synchronous clear of ones_count (wins over an increment)
//   p_out      out  registered p-bit state (1 = +1, 0 = -1)
//   upd_ack    out  one-cycle pulse when p_out has just been updated
//   busy       out  high while in SETTLE or SAMPLE
//   ones_count out  saturating count of updates that produced p = 1
// -----------------------------------------------------------------------------
module pbit_neuron #(
    parameter int          weight_precision = 6,
    parameter int          SETTLE_CYCLES    = 2,
    parameter logic [15:0] SEED             = 16'hACE1,
    parameter logic        P_INIT           = 1'b0,
    parameter int          COUNT_WIDTH      = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               upd_req,
    input  logic signed [weight_precision-1:0] I_in,
    input  logic                               clr_count,
    output logic                               p_out,
    output logic                               upd_ack,
    output logic                               busy,
    output logic [COUNT_WIDTH-1:0]             ones_count
);

    // A zero seed would lock the LFSR at zero, so it is replaced.
    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    localparam logic [7:0]             SETTLE_LOAD = 8'(SETTLE_CYCLES);
    localparam logic                   SKIP_SETTLE = (SETTLE_CYCLES == 32'sd0);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO    = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;

    // Taps 16,14,13,11 give a maximal-length sequence that never reaches zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic fb;
        fb = l[15] ^ l[13] ^ l[12] ^ l[10];
        return {l[14:0], fb};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]             r_state;
    logic [7:0]             r_settle_cnt;
    logic [15:0]            r_lfsr;
    logic                   r_p;
    logic                   r_ack;
    logic                   r_busy;
    logic [COUNT_WIDTH-1:0] r_count;

    logic [1:0]                          w_state_nxt;
    logic [7:0]                          w_settle_nxt;
    logic signed [weight_precision-1:0]  w_rand;
    logic                                w_sample;
    logic                                w_p_new;
    logic [COUNT_WIDTH-1:0]              w_count_nxt;

    // The comparand is the LFSR value of the current cycle; both operands
    // have the same signed width so the compare cannot overflow.
    assign w_rand   = $signed(r_lfsr[weight_precision-1:0]);
    assign w_sample = (r_state == ST_SAMPLE);
    assign w_p_new  = (I_in > w_rand);

    // Next-state and settle-counter logic for the update sequencer.
    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle_cnt;
        case (r_state)
            ST_IDLE: begin
                if (upd_req) begin
                    if (SKIP_SETTLE) begin
                        w_state_nxt  = ST_SAMPLE;
                        w_settle_nxt = 8'd0;
                    end else begin
                        w_state_nxt  = ST_SETTLE;
                        w_settle_nxt = SETTLE_LOAD;
                    end
                end else begin
                    w_state_nxt  = ST_IDLE;
                    w_settle_nxt = r_settle_cnt;
                end
            end
            ST_SETTLE: begin
                // Leaving on a count of 1 makes SETTLE last exactly
                // SETTLE_CYCLES cycles; a count of 0 can only come from an
                // upset and is treated the same way so the FSM cannot stall.
                if (r_settle_cnt <= 8'd1) begin
                    w_state_nxt  = ST_SAMPLE;
                    w_settle_nxt = 8'd0;
                end else begin
                    w_state_nxt  = ST_SETTLE;
                    w_settle_nxt = r_settle_cnt - 8'd1;
                end
            end
            ST_SAMPLE: begin
                w_state_nxt  = ST_IDLE;
                w_settle_nxt = 8'd0;
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_settle_nxt = 8'd0;
            end
        endcase
    end

    // Ones counter next value: clear wins, otherwise saturating increment.
    always_comb begin
        w_count_nxt = r_count;
        if (clr_count) begin
            w_count_nxt = CNT_ZERO;
        end else if (w_sample && w_p_new && (r_count != CNT_MAX)) begin
            w_count_nxt = r_count + CNT_ONE;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Free-running random source, advancing every cycle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_INIT;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    // Sequencer state, settle counter and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= 8'd0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

    // p-bit state and the acknowledge pulse, both updated on the SAMPLE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p   <= P_INIT;
            r_ack <= 1'b0;
        end else begin
            if (w_sample) begin
                r_p <= w_p_new;
            end else begin
                r_p <= r_p;
            end
            r_ack <= w_sample;
        end
    end

    // Saturating count of updates that produced p = 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= CNT_ZERO;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign p_out      = r_p;
    assign upd_ack    = r_ack;
    assign busy       = r_busy;
    assign ones_count = r_count;

endmodule

// File: tb/tb_pbit_neuron.sv
// -----------------------------------------------------------------------------
// tb_pbit_neuron
//
// Directed bench for pbit_neuron. Two instances share clock and reset:
//   A: SETTLE_CYCLES=3, SEED=16'hACE1, P_INIT=1, COUNT_WIDTH=16
//   B: SETTLE_CYCLES=0, SEED=0,        P_INIT=0, COUNT_WIDTH=4
// B's zero seed must fall back to 16'hACE1, so one reference LFSR serves both.
// Expected p values come from that reference LFSR and the strict signed
// comparison I_in > rand.
// -----------------------------------------------------------------------------
module tb_pbit_neuron;

    logic clk;
    logic rst_n;

    logic              a_req, a_clr, a_p, a_ack, a_busy;
    logic signed [5:0] a_I;
    logic [15:0]       a_cnt;

    logic              b_req, b_clr, b_p, b_ack, b_busy;
    logic signed [5:0] b_I;
    logic [3:0]        b_cnt;

    int checks;
    int errors;
    int exp_cnt_a;
    int exp_cnt_b;

    logic [15:0] m_lfsr;

    pbit_neuron #(
        .weight_precision(6),
        .SETTLE_CYCLES   (3),
        .SEED            (16'hACE1),
        .P_INIT          (1'b1),
        .COUNT_WIDTH     (16)
    ) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .upd_req   (a_req),
        .I_in      (a_I),
        .clr_count (a_clr),
        .p_out     (a_p),
        .upd_ack   (a_ack),
        .busy      (a_busy),
        .ones_count(a_cnt)
    );

    pbit_neuron #(
        .weight_precision(6),
        .SETTLE_CYCLES   (0),
        .SEED            (16'h0000),
        .P_INIT          (1'b0),
        .COUNT_WIDTH     (4)
    ) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .upd_req   (b_req),
        .I_in      (b_I),
        .clr_count (b_clr),
        .p_out     (b_p),
        .upd_ack   (b_ack),
        .busy      (b_busy),
        .ones_count(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: 16'hACE1 after reset, taps 16,14,13,11.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
        end else begin
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // n back-to-back updates with upd_req held high; every cycle of each
    // update is checked, so ack spacing of SETTLE_CYCLES+2 is enforced.
    task automatic run_upd(input bit sel_b, input int n, input logic signed [5:0] iv);
        int                s;
        logic              e;
        logic signed [5:0] r;
        int                cmax;
        s    = sel_b ? 0 : 3;
        cmax = sel_b ? 15 : 65535;
        if (sel_b) begin
            b_I = iv; b_req = 1'b1;
        end else begin
            a_I = iv; a_req = 1'b1;
        end
        for (int u = 0; u < n; u++) begin
            @(posedge clk); #1;
            if (u == n - 1) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
            check_eq("acc_busy", sel_b ? b_busy : a_busy, 1);
            check_eq("acc_ack",  sel_b ? b_ack  : a_ack,  0);
            for (int j = 0; j < s; j++) begin
                @(posedge clk); #1;
                check_eq("settle_busy", sel_b ? b_busy : a_busy, 1);
                check_eq("settle_ack",  sel_b ? b_ack  : a_ack,  0);
            end
            r = m_lfsr[5:0];
            e = (iv > r);
            @(posedge clk); #1;
            check_eq("upd_ack",  sel_b ? b_ack  : a_ack,  1);
            check_eq("upd_p",    sel_b ? b_p    : a_p,    e);
            check_eq("upd_busy", sel_b ? b_busy : a_busy, 0);
            if (sel_b) begin
                if (e && exp_cnt_b < cmax) exp_cnt_b = exp_cnt_b + 1;
                check_eq("b_cnt", b_cnt, exp_cnt_b);
            end else begin
                if (e && exp_cnt_a < cmax) exp_cnt_a = exp_cnt_a + 1;
                check_eq("a_cnt", a_cnt, exp_cnt_a);
            end
        end
    endtask

    // Watchdog: all waits are fixed cycle counts, this only guards the run.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic              e;
        logic signed [5:0] r;
        checks = 0; errors = 0; exp_cnt_a = 0; exp_cnt_b = 0;
        rst_n = 1'b0;
        a_req = 1'b0; a_clr = 1'b0; a_I = 6'sd0;
        b_req = 1'b0; b_clr = 1'b0; b_I = 6'sd0;
        repeat (2) @(posedge clk);
        #1;
        // Reset values
        check_eq("rst_a_p",    a_p,    1);
        check_eq("rst_a_ack",  a_ack,  0);
        check_eq("rst_a_busy", a_busy, 0);
        check_eq("rst_a_cnt",  a_cnt,  0);
        check_eq("rst_b_p",    b_p,    0);
        check_eq("rst_b_ack",  b_ack,  0);
        check_eq("rst_b_busy", b_busy, 0);
        check_eq("rst_b_cnt",  b_cnt,  0);
        rst_n = 1'b1;

        // A: single update, I=31, with a second request while busy
        a_I = 6'sd31; a_req = 1'b1;
        @(posedge clk); #1;                 // edge k: accepted, req held
        check_eq("k0_busy", a_busy, 1);
        check_eq("k0_ack",  a_ack,  0);
        @(posedge clk); #1;                 // edge k+1: req ignored
        a_req = 1'b0;
        check_eq("k1_busy", a_busy, 1);
        check_eq("k1_ack",  a_ack,  0);
        @(posedge clk); #1;
        check_eq("k2_busy", a_busy, 1);
        check_eq("k2_ack",  a_ack,  0);
        @(posedge clk); #1;
        check_eq("k3_busy", a_busy, 1);
        check_eq("k3_ack",  a_ack,  0);
        r = m_lfsr[5:0];
        e = (6'sd31 > r);
        @(posedge clk); #1;                 // edge k+4
        check_eq("k4_ack",  a_ack,  1);
        check_eq("k4_p",    a_p,    e);
        check_eq("k4_busy", a_busy, 0);
        exp_cnt_a = e ? 1 : 0;
        check_eq("k4_cnt",  a_cnt,  exp_cnt_a);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_eq("no_extra_ack",  a_ack,  0);
            check_eq("no_extra_busy", a_busy, 0);
        end

        // A: clear, then I=-32 x200, I=31 x64
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        check_eq("a_clr", a_cnt, 0);
        exp_cnt_a = 0;
        run_upd(1'b0, 200, 6'sb100000);
        check_eq("a_min_cnt", a_cnt, 0);
        run_upd(1'b0, 64, 6'sd31);

        // A: I=0 x1024, statistics window
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        exp_cnt_a = 0;
        run_upd(1'b0, 1024, 6'sd0);
        check_eq("a_zero_range", ((a_cnt >= 16'd448) && (a_cnt <= 16'd576)), 1);

        // B: zero seed, zero settle, 4-bit counter
        run_upd(1'b1, 64, 6'sd0);
        b_clr = 1'b1;
        @(posedge clk); #1;
        b_clr = 1'b0;
        check_eq("b_clr", b_cnt, 0);
        exp_cnt_b = 0;
        run_upd(1'b1, 40, 6'sd31);
        check_eq("b_sat", b_cnt, 15);

        // B: clear coinciding with a SAMPLE edge
        b_I = 6'sd31; b_req = 1'b1;
        @(posedge clk); #1;
        b_req = 1'b0; b_clr = 1'b1;
        check_eq("bc_busy", b_busy, 1);
        r = m_lfsr[5:0];
        e = (6'sd31 > r);
        @(posedge clk); #1;
        b_clr = 1'b0;
        check_eq("bc_ack", b_ack, 1);
        check_eq("bc_p",   b_p,   e);
        check_eq("bc_cnt", b_cnt, 0);
        exp_cnt_b = 0;

        // A: reset in the middle of SETTLE
        run_upd(1'b0, 1, 6'sb100000);
        check_eq("pre_rst_p", a_p, 0);
        a_I = 6'sd31; a_req = 1'b1;
        @(posedge clk); #1;
        a_req = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_busy", a_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mr_p",    a_p,    1);
        check_eq("mr_busy", a_busy, 0);
        check_eq("mr_ack",  a_ack,  0);
        check_eq("mr_cnt",  a_cnt,  0);
        @(posedge clk); #1;
        check_eq("mr_ack2", a_ack,  0);
        rst_n = 1'b1;
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        run_upd(1'b0, 8, 6'sd0);
        run_upd(1'b1, 8, 6'sd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
